spi_slave_regif: RTL

- Byte-oriented SPI slave (mode 0: CPOL=0, CPHA=0) running entirely in the PCLK domain. It oversamples SCK, SS and MOSI through synchronizers.
- It is the responder-side counterpart to the SPI master: same WR/DR strobe register style, same PRDATA/PWDATA bus.
- Peripherals use it to receive command/data bytes and return one response byte per frame byte.

---
 rtl/spi_slave_regif.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/spi_slave_regif.sv
//------------------------------------------------------------------------------
// Module   : spi_slave_regif
// Purpose  : Mode-0 SPI slave with strobe-style register interface, PCLK domain.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_slave_regif #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_PCLK,
  input  logic              i_PRESETn,
  input  logic              i_WR0,
  input  logic              i_WR1,
  input  logic              i_DR0,
  input  logic              i_DR1,
  input  logic [DATA_W-1:0] i_PWDATA,
  output logic [DATA_W-1:0] o_PRDATA,
  input  logic              SCK,
  input  logic              SS,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  output logic              o_rx_irq
);

  localparam int c_CNT_W = $clog2(DATA_W + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_W - 1);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SHIFT  = 2'd2,
    S_RELOAD = 2'd3
  } state_t;

  state_t                   r_state;
  logic [SYNC_STAGES-1:0]   r_sck_sync, r_ss_sync, r_mosi_sync;
  logic                     r_sck_d, r_ss_d;
  logic                     r_en, r_lsb;
  logic [DATA_W-1:0]        r_tx_buf, r_rx_buf, r_tx_sh, r_rx_sh;
  logic                     r_tx_empty, r_rx_full, r_overrun, r_underrun, r_frame_err;
  logic [c_CNT_W-1:0]       r_bit_cnt;
  logic                     r_miso, r_miso_oe;

  logic                     w_sck, w_ss, w_mosi;
  logic                     w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall;
  logic                     w_do_load, w_load_bit, w_tx_next_bit;
  logic [DATA_W-1:0]        w_load_data, w_tx_next, w_rx_next, w_status;
  logic                     w_unused_pwdata;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_ss       = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_ss_rise  = w_ss & ~r_ss_d;
  assign w_ss_fall  = ~w_ss & r_ss_d;

  // A deselect arriving with the reload fall wins, leaving tx_buf unconsumed.
  assign w_do_load  = (r_state == S_LOAD) ||
                      ((r_state == S_RELOAD) && w_sck_fall && !w_ss_rise);

  assign w_load_data   = r_tx_empty ? '0 : r_tx_buf;
  assign w_load_bit    = r_lsb ? w_load_data[0] : w_load_data[DATA_W-1];
  assign w_tx_next     = r_lsb ? (r_tx_sh >> 1) : (r_tx_sh << 1);
  assign w_tx_next_bit = r_lsb ? w_tx_next[0] : w_tx_next[DATA_W-1];
  assign w_rx_next     = r_lsb ? {w_mosi, r_rx_sh[DATA_W-1:1]}
                               : {r_rx_sh[DATA_W-2:0], w_mosi};

  assign w_status = DATA_W'({(r_state != S_IDLE), r_frame_err, r_underrun,
                             r_overrun, r_tx_empty, r_rx_full});

  assign o_PRDATA = i_DR0 ? w_status : (i_DR1 ? r_rx_buf : '0);
  assign MISO     = r_miso;
  assign MISO_OE  = r_miso_oe;
  assign o_rx_irq = r_rx_full;

  assign w_unused_pwdata = &{1'b0, i_PWDATA[DATA_W-1:3]};

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      r_state     <= S_IDLE;
      r_sck_sync  <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_ss_d      <= 1'b1;
      r_en        <= 1'b0;
      r_lsb       <= 1'b0;
      r_tx_buf    <= '0;
      r_rx_buf    <= '0;
      r_tx_sh     <= '0;
      r_rx_sh     <= '0;
      r_tx_empty  <= 1'b1;
      r_rx_full   <= 1'b0;
      r_overrun   <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
      r_bit_cnt   <= '0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sck_d     <= w_sck;
      r_ss_d      <= w_ss;

      if (i_DR1) r_rx_full <= 1'b0;

      if (i_WR0) begin
        r_en  <= i_PWDATA[0];
        r_lsb <= i_PWDATA[1];
        if (i_PWDATA[2]) begin
          r_overrun   <= 1'b0;
          r_underrun  <= 1'b0;
          r_frame_err <= 1'b0;
        end
      end

      if (w_do_load) begin
        r_tx_sh    <= w_load_data;
        r_miso     <= w_load_bit;
        r_miso_oe  <= 1'b1;
        r_tx_empty <= 1'b1;
        r_bit_cnt  <= '0;
        r_state    <= S_SHIFT;
        if (r_tx_empty) r_underrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: if (w_ss_fall && r_en) r_state <= S_LOAD;
        S_SHIFT: begin
          if (w_sck_rise) begin
            r_rx_sh   <= w_rx_next;
            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            if (r_bit_cnt == c_LAST) begin
              r_rx_buf  <= w_rx_next;
              r_rx_full <= 1'b1;
              if (r_rx_full) r_overrun <= 1'b1;
              r_state   <= S_RELOAD;
            end
          end else if (w_sck_fall) begin
            r_tx_sh <= w_tx_next;
            r_miso  <= w_tx_next_bit;
          end
        end
        default: ;
      endcase

      if (w_ss_rise) begin
        r_state   <= S_IDLE;
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b0;
        r_bit_cnt <= '0;
        if ((r_bit_cnt != '0) && (r_bit_cnt != c_FULL)) r_frame_err <= 1'b1;
      end

      // Placed last so a write coinciding with a load leaves the new byte pending.
      if (i_WR1) begin
        r_tx_buf   <= i_PWDATA;
        r_tx_empty <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
